// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared types and zigzag table for the zigzag run-length reader
package jpeg_pkg;

    // Zigzag index -> natural index (8*row + col)
    localparam logic [5:0] ZZ [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic [5:0] LAST_IDX = 6'd63;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EVAL,
        S_ZRL,
        S_EMIT,
        S_EOB,
        S_DONE
    } state_t;

    typedef struct packed {
        logic        dc;
        logic        eob;
        logic [3:0]  run;
        logic [4:0]  size;
        logic [15:0] amp;
    } sym_t;

endpackage

// File: rtl/jpeg_size_cat.sv
// rtl/jpeg_size_cat.sv - signed coefficient to JPEG size category and amplitude bits
module jpeg_size_cat (
    input  logic [15:0] value,
    output logic [4:0]  size,
    output logic [15:0] amp
);

    logic [15:0] sat;
    logic [15:0] mag;
    logic [15:0] mask;

    always_comb begin
        // -32768 has no 15-bit magnitude; fold it onto -32767
        sat  = (value == 16'h8000) ? 16'h8001 : value;
        mag  = sat[15] ? (~sat + 16'd1) : sat;
        size = '0;
        for (int b = 0; b < 15; b++) begin
            if (mag[b]) begin
                size = 5'(b + 1);
            end
        end
        mask = 16'((17'd1 << size) - 17'd1);
        amp  = sat[15] ? ((sat - 16'd1) & mask) : sat;
    end

endmodule

// File: rtl/jpeg_zz_rle.sv
// rtl/jpeg_zz_rle.sv - zigzag reader emitting baseline JPEG run/size/amplitude symbols
module jpeg_zz_rle
    import jpeg_pkg::*;
#(
    parameter logic [8:0] BASE_ADR = 9'h000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [8:0]  mem_adr_o,
    input  logic [31:0] mem_dat_i,
    output logic        sym_valid_o,
    input  logic        sym_ready_i,
    output logic [3:0]  sym_run_o,
    output logic [4:0]  sym_size_o,
    output logic [15:0] sym_amp_o,
    output logic        sym_dc_o,
    output logic        sym_eob_o
);

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  run_q, run_d;
    logic [4:0]  size_q, size_d;
    logic [15:0] amp_q, amp_d;

    logic [5:0]  nat;
    logic [15:0] coef;
    logic [4:0]  cat_size;
    logic [15:0] cat_amp;
    sym_t        sym;
    logic        valid;

    assign nat       = ZZ[idx_q];
    assign coef      = nat[0] ? mem_dat_i[15:0] : mem_dat_i[31:16];
    assign mem_adr_o = BASE_ADR + {4'd0, nat[5:1]};

    jpeg_size_cat u_size_cat (
        .value (coef),
        .size  (cat_size),
        .amp   (cat_amp)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            run_q   <= '0;
            size_q  <= '0;
            amp_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            size_q  <= size_d;
            amp_q   <= amp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        run_d   = run_q;
        size_d  = size_q;
        amp_d   = amp_q;
        sym     = '0;
        valid   = 1'b0;
        busy_o  = (state_q != S_IDLE);
        done_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    idx_d   = '0;
                    run_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_EVAL;
            end
            S_EVAL: begin
                size_d = cat_size;
                amp_d  = cat_amp;
                if (idx_q == '0) begin
                    state_d = S_EMIT;
                end else if (coef == '0) begin
                    run_d = run_q + 6'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_EOB;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = S_FETCH;
                    end
                end else if (run_q >= 6'd16) begin
                    state_d = S_ZRL;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_ZRL: begin
                valid   = 1'b1;
                sym.run = 4'd15;
                if (sym_ready_i) begin
                    run_d = run_q - 6'd16;
                    if (run_q < 6'd32) begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                valid    = 1'b1;
                sym.dc   = (idx_q == '0);
                sym.run  = run_q[3:0];
                sym.size = size_q;
                sym.amp  = amp_q;
                if (sym_ready_i) begin
                    run_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_EOB: begin
                valid   = 1'b1;
                sym.eob = 1'b1;
                if (sym_ready_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sym_valid_o = valid;
    assign sym_dc_o    = sym.dc;
    assign sym_eob_o   = sym.eob;
    assign sym_run_o   = sym.run;
    assign sym_size_o  = sym.size;
    assign sym_amp_o   = sym.amp;

endmodule

// File: tb/tb_jpeg_zz_rle.sv
// tb/tb_jpeg_zz_rle.sv - directed and randomized-stall bench for jpeg_zz_rle
module tb_jpeg_zz_rle;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy_o;
    logic        done_o;
    logic [8:0]  mem_adr;
    logic [31:0] mem_dat;
    logic        sym_valid;
    logic        sym_ready;
    logic [3:0]  sym_run;
    logic [4:0]  sym_size;
    logic [15:0] sym_amp;
    logic        sym_dc;
    logic        sym_eob;

    always #5 clk = ~clk;

    jpeg_zz_rle #(.BASE_ADR(9'h000)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .mem_adr_o   (mem_adr),
        .mem_dat_i   (mem_dat),
        .sym_valid_o (sym_valid),
        .sym_ready_i (sym_ready),
        .sym_run_o   (sym_run),
        .sym_size_o  (sym_size),
        .sym_amp_o   (sym_amp),
        .sym_dc_o    (sym_dc),
        .sym_eob_o   (sym_eob)
    );

    logic [31:0]        mem [0:31];
    logic signed [15:0] coef [64];
    int                 zz [64];
    logic [26:0]        exp_q [$];
    logic [26:0]        got_q [$];
    logic [26:0]        held;
    logic [26:0]        cur;
    bit                 held_pend = 1'b0;
    int                 stall_pct = 0;
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 model_lat;

    localparam logic [26:0] ZRL = {1'b0, 1'b0, 4'd15, 5'd0, 16'd0};
    localparam logic [26:0] EOB = {1'b0, 1'b1, 4'd0, 5'd0, 16'd0};

    always @(posedge clk) mem_dat <= mem[mem_adr[4:0]];

    always @(posedge clk) begin
        #1;
        sym_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    // Stream monitor: captures transfers and checks stability while stalled
    always @(negedge clk) begin
        if (rst) begin
            held_pend = 1'b0;
        end else begin
            cur = {sym_dc, sym_eob, sym_run, sym_size, sym_amp};
            if (held_pend) chk("hold", {sym_valid, cur}, {1'b1, held});
            if (sym_valid && sym_ready) begin
                got_q.push_back(cur);
                held_pend = 1'b0;
            end else if (sym_valid) begin
                held      = cur;
                held_pend = 1'b1;
            end else begin
                held_pend = 1'b0;
            end
        end
    end

    function automatic logic [26:0] hs(bit dc, int run, int size, int amp);
        return {dc, 1'b0, 4'(run), 5'(size), 16'(amp)};
    endfunction

    function automatic logic [26:0] mk_sym(bit dc, int run, logic signed [15:0] v);
        int m, t, sz, va, a;
        m  = (v < 0) ? -int'(v) : int'(v);
        if (m == 32768) m = 32767;
        va = (v < 0) ? -m : m;
        sz = 0;
        t  = m;
        while (t > 0) begin
            sz++;
            t = t >> 1;
        end
        a = (va < 0) ? va + (1 << sz) - 1 : va;
        return hs(dc, run, sz, a);
    endfunction

    task automatic build_model();
        int run;
        int lat;
        exp_q.delete();
        run = 0;
        lat = 3;
        exp_q.push_back(mk_sym(1'b1, 0, coef[zz[0]]));
        for (int k = 1; k < 64; k++) begin
            if (coef[zz[k]] == 0) begin
                run++;
                lat += 2;
            end else begin
                while (run >= 16) begin
                    exp_q.push_back(ZRL);
                    run -= 16;
                    lat++;
                end
                exp_q.push_back(mk_sym(1'b0, run, coef[zz[k]]));
                run = 0;
                lat += 3;
            end
        end
        if (run > 0) begin
            exp_q.push_back(EOB);
            lat++;
        end
        model_lat = lat;
    endtask

    task automatic clear_coef();
        for (int n = 0; n < 64; n++) coef[n] = '0;
    endtask

    task automatic run_block(input string name, input int exp_lat, input bit restart);
        int cyc;
        got_q.delete();
        for (int w = 0; w < 32; w++) mem[w] = {coef[2*w], coef[2*w+1]};
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        cyc = 0;
        while (!done_o && cyc < 5000) begin
            @(posedge clk);
            #2;
            cyc++;
            start = restart && (cyc == 20);
        end
        start = 1'b0;
        chk({name, ":done"}, {63'd0, done_o}, 64'd1);
        chk({name, ":busy_done"}, {63'd0, busy_o}, 64'd1);
        if (exp_lat >= 0) chk({name, ":latency"}, 64'(cyc), 64'(exp_lat));
        @(posedge clk);
        #2;
        chk({name, ":idle"}, {62'd0, busy_o, done_o}, 64'd0);
        chk({name, ":count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int s = 0; s < exp_q.size() && s < got_q.size(); s++)
            chk($sformatf("%s:sym%0d", name, s), 64'(got_q[s]), 64'(exp_q[s]));
    endtask

    function automatic logic [38:0] all_outs();
        return {busy_o, done_o, mem_adr, sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_eob};
    endfunction

    initial begin
        int k;
        int wait_cyc;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz[k] = 8 * r + (s - r);
                    k++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
                    zz[k] = 8 * r + (s - r);
                    k++;
                end
            end
        end

        rst   = 1'b1;
        start = 1'b0;
        clear_coef();
        for (int w = 0; w < 32; w++) mem[w] = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs", 64'(all_outs()), 64'd0);
        rst = 1'b0;

        // DC only
        clear_coef();
        coef[0] = 16'sd5;
        exp_q = '{hs(1, 0, 3, 5), EOB};
        run_block("dc5", 130, 1'b0);

        // negative DC and first AC
        clear_coef();
        coef[0] = -16'sd3;
        coef[1] = -16'sd1;
        exp_q = '{hs(1, 0, 2, 0), hs(0, 0, 1, 0), EOB};
        run_block("neg", 131, 1'b0);

        // zigzag 40 is natural 29: two ZRLs then run 7
        clear_coef();
        coef[29] = 16'sd7;
        exp_q = '{hs(1, 0, 0, 0), ZRL, ZRL, hs(0, 7, 3, 7), EOB};
        run_block("zz40", 133, 1'b0);

        // last coefficient nonzero: no EOB
        clear_coef();
        coef[63] = 16'sd1;
        exp_q = '{hs(1, 0, 0, 0), ZRL, ZRL, ZRL, hs(0, 14, 1, 1)};
        run_block("zz63", 133, 1'b0);

        // saturation extremes
        clear_coef();
        coef[0] = -16'sd32768;
        coef[1] = 16'sd32767;
        exp_q = '{hs(1, 0, 15, 0), hs(0, 0, 15, 32767), EOB};
        run_block("sat", 131, 1'b0);

        // random block, ready always high, latency from model
        for (int n = 0; n < 64; n++)
            coef[n] = ($urandom_range(0, 9) < 6) ? 16'sd0 : 16'($urandom_range(0, 600)) - 16'sd300;
        coef[zz[17]] = -16'sd32768;
        build_model();
        run_block("rnd_a", model_lat, 1'b0);

        // random block with stalls and an ignored restart
        for (int n = 0; n < 64; n++)
            coef[n] = ($urandom_range(0, 9) < 7) ? 16'sd0 : 16'($urandom_range(0, 4000)) - 16'sd2000;
        coef[zz[33]] = -16'sd32768;
        coef[63] = 16'sd0;
        build_model();
        stall_pct = 40;
        run_block("rnd_b", -1, 1'b1);

        // reset during EMIT with ready held low
        clear_coef();
        coef[0] = 16'sd5;
        coef[5] = -16'sd9;
        for (int w = 0; w < 32; w++) mem[w] = {coef[2*w], coef[2*w+1]};
        stall_pct = 100;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_cyc = 0;
        while (!sym_valid && wait_cyc < 50) begin
            @(posedge clk);
            #2;
            wait_cyc++;
        end
        chk("abort:in_emit", {62'd0, sym_valid, sym_dc}, 64'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("abort:outs", 64'(all_outs()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("abort:idle", 64'(all_outs()), 64'd0);
        stall_pct = 30;
        build_model();
        run_block("after_abort", -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
